if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch front end for the 5-stage RISC-V core: it owns the fetch PC, drives the instruction memory, and buffers fetched {pc, instruction} pairs in a DEPTH-entry queue. It replaces the PC / PC+4 adder / IF_ID pairing with a decoupled fetch stage. Decode stalls (load-use) and branch redirects (ID-stage flush) no longer freeze fetch immediately. Sits between Instruction_Memory and the ID stage.

## Interface
- XLEN, 32: PC and instruction-address width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: fetch PC after reset.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  fetch enable; no new fetches while low.
- imem_addr_o  out  XLEN  fetch address to combinational instruction memory.
- imem_instr_i  in  32  instruction at imem_addr_o, same cycle.
- redirect_i  in  1  branch taken / flush from ID.
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored (treated as 0).
- deq_ready_i  in  1  decode accepts head this cycle (low = stall).
- deq_valid_o  out  1  head entry valid.
- deq_pc_o  out  XLEN  PC of head entry.
- deq_instr_o  out  32  instruction of head entry.
- count_o  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH.

## Operation
- State: fetch_pc (XLEN), DEPTH×(XLEN+32) storage, rd_ptr/wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count.
- imem_addr_o = fetch_pc, always.
- deq = deq_valid_o & deq_ready_i.
- push = start_i & !redirect_i & (count < DEPTH | deq).
  - On push: write {fetch_pc, imem_instr_i} at wr_ptr; wr_ptr++; fetch_pc += 4 (modulo 2^XLEN).
  - No push: fetch_pc holds.
- deq_valid_o = (count != 0) & !redirect_i. On deq: rd_ptr++.
- count next = count + push − deq. Full with simultaneous deq and push: count stays DEPTH.
- Redirect has priority over everything:
  - count, rd_ptr and wr_ptr go to 0.
  - fetch_pc ← {redirect_pc_i[XLEN-1:2], 2'b00}.
  - No push and no deq that cycle.
- deq_pc_o and deq_instr_o are 0 whenever deq_valid_o is 0; otherwise they show the head entry.
- start_i low: fetch halts, the queue drains normally, and redirects still apply.

## Timing
- Reset values:
  - imem_addr_o = RESET_PC.
  - deq_valid_o = 0, deq_pc_o = 0, deq_instr_o = 0, count_o = 0.
  - All pointers 0.
- Reset asserted mid-operation clears the queue and fetch_pc asynchronously. The first fetch is on the first edge with rst_i low and start_i high.
- Fetch-to-dequeue latency: 1 cycle. Sustained throughput: 1 instruction/cycle while deq_ready_i is high.
- Redirect in cycle N:
  - Target fetched in cycle N+1.
  - Target visible at dequeue in N+2.
- Stall with deq_ready_i low: the queue fills in DEPTH cycles, then fetch_pc freezes. On deq_ready_i high, a dequeue and a push happen in the same cycle with no bubble.

## Configuration
- FETCH_BYPASS_EN defined:
  - When count == 0 and push is true, deq_valid_o is 1 and deq_pc_o/deq_instr_o = fetch_pc/imem_instr_i combinationally.
  - If deq_ready_i is also 1, the entry is consumed directly and not written; count stays 0.
  - Fetch-to-dequeue latency becomes 0 cycles; redirect penalty becomes 1 cycle (target dequeued in N+1).
- FETCH_BYPASS_EN undefined: registered path only, as specified above.

## Test plan
- Reset, then start_i=1, deq_ready_i=1, RESET_PC=0, imem returns addr^32'hA5A5_0000 -> deq_pc_o 0,4,8,… on consecutive cycles starting one cycle after the first fetch; count_o stays ≤1.
- deq_ready_i=0 for 10 cycles with DEPTH=4 -> count_o reaches 4 after 4 cycles; imem_addr_o freezes at 16; on release, 0,4,8,12,16 are dequeued without a gap.
- Redirect with redirect_pc_i=32'h103 while 3 entries are queued -> same cycle deq_valid_o=0; next cycle count_o=0 and imem_addr_o=32'h100; deq_pc_o=32'h100 one cycle later (same cycle with FETCH_BYPASS_EN).
- Full queue with deq_ready_i=1 and start_i=1 -> count_o holds at 4 and one push plus one deq occur per cycle.
- fetch_pc=32'hFFFF_FFFC, push -> next imem_addr_o=0; over 2·DEPTH pushes and pops, pointer wrap keeps entries in order.
- rst_i pulsed asynchronously mid-stream with 2 entries queued -> deq_valid_o and count_o drop to 0 before the next edge; imem_addr_o = RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Decoupled instruction-fetch front end: owns the fetch PC and buffers {pc, instr} pairs for decode.
// Define FETCH_BYPASS_EN to let an empty queue forward the current fetch straight to dequeue.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic [XLEN-1:0]          imem_addr_o,
    input  logic [31:0]              imem_instr_i,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    input  logic                     deq_ready_i,
    output logic                     deq_valid_o,
    output logic [XLEN-1:0]          deq_pc_o,
    output logic [31:0]              deq_instr_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            stored_vld, deq, push, wr_en, byp_vld;

    // Dequeue from storage is computed without the bypass term so push never loops back on itself.
    assign stored_vld = (count != '0) & ~redirect_i;
    assign deq        = stored_vld & deq_ready_i;
    assign push       = start_i & ~redirect_i & ((count != FULL) | deq);

`ifdef FETCH_BYPASS_EN
    assign byp_vld = (count == '0) & push;
    assign wr_en   = push & ~(byp_vld & deq_ready_i);
`else
    assign byp_vld = 1'b0;
    assign wr_en   = push;
`endif

    assign head        = mem[rd_ptr];
    assign imem_addr_o = fetch_pc;
    assign count_o     = count;

    always_comb begin
        deq_valid_o = stored_vld | byp_vld;
        deq_pc_o    = '0;
        deq_instr_o = '0;
        if (stored_vld) begin
            deq_pc_o    = head.pc;
            deq_instr_o = head.instr;
        end else if (byp_vld) begin
            deq_pc_o    = fetch_pc;
            deq_instr_o = imem_instr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i & ~XLEN'(3);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push)  fetch_pc <= fetch_pc + XLEN'(4);
            if (wr_en) wr_ptr   <= wr_ptr + 1'b1;
            if (deq)   rd_ptr   <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(deq);
        end
    end

    // Storage needs no reset: entries are only observed while count says they are live.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr_i};
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a queue-based fetch model predicts dequeues, a monitor checks them.
// Honours FETCH_BYPASS_EN the same way as the design build.
module tb_if_fetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst, start, redir, ready, dvld;
    logic [31:0] rpc, addr, instr, dpc, dinstr;
    logic [2:0]  cnt;

    always #5 clk = ~clk;
    assign instr = addr ^ 32'hA5A5_0000;

    if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .imem_addr_o(addr), .imem_instr_i(instr),
        .redirect_i(redir), .redirect_pc_i(rpc), .deq_ready_i(ready), .deq_valid_o(dvld),
        .deq_pc_o(dpc), .deq_instr_o(dinstr), .count_o(cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        mon_e;
    logic [31:0] mpc;
    bit          exp_vld, mon_en;
    int          exp_cnt;
    bit          p_redir, p_push, p_early;
    logic [31:0] p_tgt;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(logic [31:0] pc);
        ent_t e;
        e.pc    = pc;
        e.instr = pc ^ 32'hA5A5_0000;
        return e;
    endfunction

    // One cycle: retire the model effects of the previous edge, then issue new inputs and predictions.
    task automatic step(bit s, bit r, bit rd, logic [31:0] t);
        int sz;
        bit deq_m, push_m;
        @(negedge clk);
        if (p_redir) begin
            exp_q.delete();
            mpc = t_align(p_tgt);
        end else if (p_push) begin
            if (!p_early) exp_q.push_back(mk(mpc));
            mpc += 32'd4;
        end
        start = s; ready = r; redir = rd; rpc = t;
        sz     = exp_q.size();
        deq_m  = (sz != 0) && !rd && r;
        push_m = s && !rd && ((sz < DEPTH) || deq_m);
        p_early = 1'b0;
`ifdef FETCH_BYPASS_EN
        if (sz == 0 && push_m) begin
            exp_q.push_back(mk(mpc));
            p_early = 1'b1;
        end
`endif
        exp_cnt = sz;
        exp_vld = (exp_q.size() != 0) && !rd;
        p_redir = rd; p_tgt = t; p_push = push_m;
        mon_en  = 1'b1;
    endtask

    function automatic logic [31:0] t_align(logic [31:0] t);
        return {t[31:2], 2'b00};
    endfunction

    task automatic async_rst();
        @(negedge clk);
        mon_en = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", dvld, 0);
        chk("arst_count", cnt, 0);
        chk("arst_addr", addr, RESET_PC);
        chk("arst_pc", dpc, 0);
        exp_q.delete();
        mpc = RESET_PC;
        p_redir = 0; p_push = 0; p_early = 0;
        @(negedge clk);
        start = 0; redir = 0; rst = 1'b0;
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard head.
    always begin
        @(negedge clk);
        #2;
        if (mon_en && !rst) begin
            chk("deq_valid", dvld, exp_vld);
            chk("count", cnt, exp_cnt);
            chk("imem_addr", addr, mpc);
            if (dvld && ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL deq_unexpected: got pc %0h expected no dequeue", dpc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("deq_pc", dpc, mon_e.pc);
                    chk("deq_instr", dinstr, mon_e.instr);
                end
            end else if (!dvld) begin
                chk("idle_pc", dpc, 0);
                chk("idle_instr", dinstr, 0);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 0; redir = 0; ready = 0; rpc = '0;
        mpc = RESET_PC; mon_en = 0;
        p_redir = 0; p_push = 0; p_early = 0; p_tgt = '0;
        repeat (2) @(negedge clk);
        chk("rst_addr", addr, RESET_PC);
        chk("rst_valid", dvld, 0);
        chk("rst_count", cnt, 0);
        chk("rst_pc", dpc, 0);
        chk("rst_instr", dinstr, 0);
        rst = 1'b0;

        repeat (12) step(1, 1, 0, 0);                     // streaming
        step(0, 1, 1, 32'h0);
        repeat (10) step(1, 0, 0, 0);                     // stall fills queue
        repeat (8)  step(1, 1, 0, 0);                     // release, no bubble
        step(0, 1, 1, 32'h0);
        repeat (3)  step(1, 0, 0, 0);
        step(1, 1, 1, 32'h103);                           // redirect with entries queued
        repeat (4)  step(1, 1, 0, 0);
        repeat (5)  step(1, 0, 0, 0);
        repeat (6)  step(1, 1, 0, 0);                     // full, push+deq each cycle
        step(0, 1, 1, 32'hFFFF_FFFC);                     // PC wrap and pointer wrap
        for (int i = 0; i < 4 * DEPTH; i++) step(1, ($urandom_range(0, 2) != 0), 0, 0);
        step(0, 1, 1, 32'h40);
        repeat (2)  step(1, 0, 0, 0);
        async_rst();
        repeat (6)  step(1, 1, 0, 0);

        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), $urandom);
        @(negedge clk);
        mon_en = 0;
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
